// File: rtl/m_ext_pkg.sv
// Shared types and constants for the RV32M execute-stage sequencer.
package m_ext_pkg;

  localparam int M_XLEN = 32;

  // Dividend that overflows signed division when divided by -1.
  localparam logic [M_XLEN-1:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } m_funct3_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL_REQ  = 3'd1,
    MUL_WAIT = 3'd2,
    DIV_REQ  = 3'd3,
    DIV_WAIT = 3'd4,
    FIXUP    = 3'd5,
    DRAIN    = 3'd6
  } m_state_t;

  // funct3[2] separates the divide family from the multiply family.
  function automatic logic is_div_op(m_funct3_t op);
    return op[2];
  endfunction

  // {rs1_signed, rs2_signed}. MUL is treated as signed x signed so that it
  // shares cache entries with MULH over the same operands.
  function automatic logic [1:0] op_signedness(m_funct3_t op);
    logic [1:0] sgn;
    case (op)
      MUL, MULH, DIV, REM: sgn = 2'b11;
      MULHSU:              sgn = 2'b10;
      default:             sgn = 2'b00;
    endcase
    return sgn;
  endfunction

endpackage

// File: rtl/m_ext_if.sv
// Bundle of the pipeline-side and arithmetic-unit-side signals of the M unit.
// slave = scheduler view, master = pipeline plus multiplier/divider view.
interface m_ext_if #(parameter int XLEN = m_ext_pkg::M_XLEN);
  import m_ext_pkg::*;

  // Pipeline side
  logic              m_valid;
  m_funct3_t         m_funct3;
  logic [XLEN-1:0]   m_rs1;
  logic [XLEN-1:0]   m_rs2;
  logic              flush;
  logic              m_stall;
  logic              m_done;
  logic [XLEN-1:0]   m_result;

  // Multiplier side
  logic              mul_enable;
  logic [XLEN-1:0]   mul_a;
  logic [XLEN-1:0]   mul_b;
  logic              mul_resp;
  logic [2*XLEN-1:0] mul_product;

  // Divider side
  logic              div_start;
  logic [XLEN-1:0]   div_dividend;
  logic [XLEN-1:0]   div_divisor;
  logic              div_done;
  logic [XLEN-1:0]   div_quotient;
  logic [XLEN-1:0]   div_remainder;

  modport master (
    output m_valid, m_funct3, m_rs1, m_rs2, flush,
    output mul_resp, mul_product, div_done, div_quotient, div_remainder,
    input  m_stall, m_done, m_result,
    input  mul_enable, mul_a, mul_b, div_start, div_dividend, div_divisor
  );

  modport slave (
    input  m_valid, m_funct3, m_rs1, m_rs2, flush,
    input  mul_resp, mul_product, div_done, div_quotient, div_remainder,
    output m_stall, m_done, m_result,
    output mul_enable, mul_a, mul_b, div_start, div_dividend, div_divisor
  );

endinterface

// File: rtl/m_ext_sign_fixup.sv
// Combinational sign handling: operand magnitudes on the way in, result
// negation and word select on the way out. The two halves are independent.
module m_ext_sign_fixup
  import m_ext_pkg::*;
#(
  parameter int XLEN = M_XLEN
) (
  // operand path
  input  m_funct3_t         op_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  output logic [XLEN-1:0]   abs_a_o,
  output logic [XLEN-1:0]   abs_b_o,
  output logic              neg_a_o,
  output logic              neg_b_o,
  // result path
  input  m_funct3_t         fix_op_i,
  input  logic              fix_neg_a_i,
  input  logic              fix_neg_b_i,
  input  logic [2*XLEN-1:0] product_i,
  input  logic [XLEN-1:0]   quotient_i,
  input  logic [XLEN-1:0]   remainder_i,
  output logic [XLEN-1:0]   result_o
);

  logic [1:0]        sgn;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  // An operand is negative only when the op treats it as signed.
  assign sgn     = op_signedness(op_i);
  assign neg_a_o = sgn[1] & rs1_i[XLEN-1];
  assign neg_b_o = sgn[0] & rs2_i[XLEN-1];
  assign abs_a_o = neg_a_o ? -rs1_i : rs1_i;
  assign abs_b_o = neg_b_o ? -rs2_i : rs2_i;

  // Re-apply signs to the unsigned results and select the returned word.
  always_comb begin
    prod_fix = (fix_neg_a_i ^ fix_neg_b_i) ? -product_i : product_i;
    quo_fix  = (fix_neg_a_i ^ fix_neg_b_i) ? -quotient_i : quotient_i;
    rem_fix  = fix_neg_a_i ? -remainder_i : remainder_i;
    result_o = '0;
    case (fix_op_i)
      MUL:                 result_o = prod_fix[XLEN-1:0];
      MULH, MULHSU, MULHU: result_o = prod_fix[2*XLEN-1:XLEN];
      DIV, DIVU:           result_o = quo_fix;
      default:             result_o = rem_fix;
    endcase
  end

endmodule

// File: rtl/m_ext_scheduler.sv
// EX-stage sequencer for RV32M: accepts one op, launches the shared
// multiplier or divider (or short-circuits), fixes up signs and returns a
// single-cycle m_done pulse with the result. Holds a one-entry product cache.
module m_ext_scheduler
  import m_ext_pkg::*;
#(
  parameter int XLEN     = M_XLEN,
  parameter bit REUSE_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  m_ext_if.slave bus
);

  localparam logic [XLEN-1:0] OVF_DIVIDEND = {1'b1, {(XLEN-1){1'b0}}};

  m_state_t          state_q, state_d;
  m_funct3_t         op_q, op_d;
  logic [1:0]        sgn_q, sgn_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [XLEN-1:0]   rs2_q, rs2_d;
  logic [XLEN-1:0]   abs_a_q, abs_a_d;
  logic [XLEN-1:0]   abs_b_q, abs_b_d;
  logic [2*XLEN-1:0] product_q, product_d;
  logic [XLEN-1:0]   quot_q, quot_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic              bypass_q, bypass_d;
  logic [XLEN-1:0]   short_q, short_d;
  logic              cache_valid_q, cache_valid_d;
  logic [XLEN-1:0]   cache_rs1_q, cache_rs1_d;
  logic [XLEN-1:0]   cache_rs2_q, cache_rs2_d;
  logic [1:0]        cache_sgn_q, cache_sgn_d;
  logic [2*XLEN-1:0] cache_product_q, cache_product_d;

  logic              mul_en;
  logic              div_st;
  logic              done;
  logic [XLEN-1:0]   in_abs_a, in_abs_b;
  logic              in_neg_a, in_neg_b;
  logic [1:0]        in_sgn;
  logic              cache_hit;
  logic              unit_done;
  logic [XLEN-1:0]   fix_result;

  m_ext_sign_fixup #(.XLEN(XLEN)) u_fixup (
    .op_i        (bus.m_funct3),
    .rs1_i       (bus.m_rs1),
    .rs2_i       (bus.m_rs2),
    .abs_a_o     (in_abs_a),
    .abs_b_o     (in_abs_b),
    .neg_a_o     (in_neg_a),
    .neg_b_o     (in_neg_b),
    .fix_op_i    (op_q),
    .fix_neg_a_i (neg_a_q),
    .fix_neg_b_i (neg_b_q),
    .product_i   (product_q),
    .quotient_i  (quot_q),
    .remainder_i (rem_q),
    .result_o    (fix_result)
  );

  assign in_sgn    = op_signedness(bus.m_funct3);
  assign cache_hit = REUSE_EN && cache_valid_q && (cache_rs1_q == bus.m_rs1) &&
                     (cache_rs2_q == bus.m_rs2) && (cache_sgn_q == in_sgn);
  assign unit_done = is_div_op(op_q) ? bus.div_done : bus.mul_resp;

  // Next-state, launch strobes and operand/result/cache register updates.
  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    sgn_d           = sgn_q;
    neg_a_d         = neg_a_q;
    neg_b_d         = neg_b_q;
    rs1_d           = rs1_q;
    rs2_d           = rs2_q;
    abs_a_d         = abs_a_q;
    abs_b_d         = abs_b_q;
    product_d       = product_q;
    quot_d          = quot_q;
    rem_d           = rem_q;
    bypass_d        = bypass_q;
    short_d         = short_q;
    cache_valid_d   = cache_valid_q;
    cache_rs1_d     = cache_rs1_q;
    cache_rs2_d     = cache_rs2_q;
    cache_sgn_d     = cache_sgn_q;
    cache_product_d = cache_product_q;
    mul_en          = 1'b0;
    div_st          = 1'b0;
    done            = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.m_valid && !bus.flush) begin
          op_d     = bus.m_funct3;
          sgn_d    = in_sgn;
          rs1_d    = bus.m_rs1;
          rs2_d    = bus.m_rs2;
          abs_a_d  = in_abs_a;
          abs_b_d  = in_abs_b;
          neg_a_d  = in_neg_a;
          neg_b_d  = in_neg_b;
          bypass_d = 1'b0;
          if (is_div_op(bus.m_funct3)) begin
            if (bus.m_rs2 == '0) begin
              // Divide by zero: quotient all ones, remainder is the dividend.
              bypass_d = 1'b1;
              short_d  = (bus.m_funct3 == DIV || bus.m_funct3 == DIVU) ? '1 : bus.m_rs1;
              state_d  = FIXUP;
            end else if (in_sgn[1] && bus.m_rs1 == OVF_DIVIDEND && bus.m_rs2 == '1) begin
              // Signed overflow: quotient is the dividend, remainder zero.
              bypass_d = 1'b1;
              short_d  = (bus.m_funct3 == DIV) ? OVF_DIVIDEND : '0;
              state_d  = FIXUP;
            end else begin
              state_d = DIV_REQ;
            end
          end else if (cache_hit) begin
            product_d = cache_product_q;
            state_d   = FIXUP;
          end else begin
            state_d = MUL_REQ;
          end
        end
      end

      MUL_REQ: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          mul_en  = 1'b1;
          state_d = MUL_WAIT;
        end
      end

      MUL_WAIT: begin
        if (bus.flush) begin
          // A response arriving with the flush is dropped here; otherwise
          // DRAIN soaks it up later.
          cache_valid_d = 1'b0;
          state_d       = bus.mul_resp ? IDLE : DRAIN;
        end else if (bus.mul_resp) begin
          product_d       = bus.mul_product;
          cache_valid_d   = 1'b1;
          cache_rs1_d     = rs1_q;
          cache_rs2_d     = rs2_q;
          cache_sgn_d     = sgn_q;
          cache_product_d = bus.mul_product;
          state_d         = FIXUP;
        end
      end

      DIV_REQ: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          div_st  = 1'b1;
          state_d = DIV_WAIT;
        end
      end

      DIV_WAIT: begin
        if (bus.flush) begin
          state_d = bus.div_done ? IDLE : DRAIN;
        end else if (bus.div_done) begin
          quot_d  = bus.div_quotient;
          rem_d   = bus.div_remainder;
          state_d = FIXUP;
        end
      end

      FIXUP: begin
        done    = !bus.flush;
        state_d = IDLE;
      end

      DRAIN: begin
        if (unit_done) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State, operand, result and cache registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      op_q            <= MUL;
      sgn_q           <= '0;
      neg_a_q         <= 1'b0;
      neg_b_q         <= 1'b0;
      rs1_q           <= '0;
      rs2_q           <= '0;
      abs_a_q         <= '0;
      abs_b_q         <= '0;
      product_q       <= '0;
      quot_q          <= '0;
      rem_q           <= '0;
      bypass_q        <= 1'b0;
      short_q         <= '0;
      cache_valid_q   <= 1'b0;
      cache_rs1_q     <= '0;
      cache_rs2_q     <= '0;
      cache_sgn_q     <= '0;
      cache_product_q <= '0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      sgn_q           <= sgn_d;
      neg_a_q         <= neg_a_d;
      neg_b_q         <= neg_b_d;
      rs1_q           <= rs1_d;
      rs2_q           <= rs2_d;
      abs_a_q         <= abs_a_d;
      abs_b_q         <= abs_b_d;
      product_q       <= product_d;
      quot_q          <= quot_d;
      rem_q           <= rem_d;
      bypass_q        <= bypass_d;
      short_q         <= short_d;
      cache_valid_q   <= cache_valid_d;
      cache_rs1_q     <= cache_rs1_d;
      cache_rs2_q     <= cache_rs2_d;
      cache_sgn_q     <= cache_sgn_d;
      cache_product_q <= cache_product_d;
    end
  end

  // Stall is held low while reset is asserted.
  assign bus.m_stall      = rst & bus.m_valid & ~done & ~bus.flush;
  assign bus.m_done       = done;
  assign bus.m_result     = done ? (bypass_q ? short_q : fix_result) : '0;
  assign bus.mul_enable   = mul_en;
  assign bus.mul_a        = abs_a_q;
  assign bus.mul_b        = abs_b_q;
  assign bus.div_start    = div_st;
  assign bus.div_dividend = abs_a_q;
  assign bus.div_divisor  = abs_b_q;

endmodule

// File: tb/tb_m_ext_scheduler.sv
// Directed bench for m_ext_scheduler with behavioural multiplier
// (2-cycle) and divider (10-cycle) models.
module tb_m_ext_scheduler;
  import m_ext_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  m_ext_if #(.XLEN(32)) bus();

  m_ext_scheduler #(.XLEN(32), .REUSE_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Multiplier model: result valid two cycles after mul_enable.
  logic        ms1_v, ms2_v;
  logic [63:0] ms1_p, ms2_p;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ms1_v <= 1'b0; ms2_v <= 1'b0; ms1_p <= '0; ms2_p <= '0;
    end else begin
      ms1_v <= bus.mul_enable;
      ms1_p <= {32'd0, bus.mul_a} * {32'd0, bus.mul_b};
      ms2_v <= ms1_v;
      ms2_p <= ms1_p;
    end
  end
  assign bus.mul_resp    = ms2_v;
  assign bus.mul_product = ms2_p;

  // Divider model: done ten cycles after the start strobe is sampled.
  logic [3:0]  dcnt;
  logic [31:0] dq, dr;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dcnt <= '0; dq <= '0; dr <= '0;
    end else if (bus.div_start) begin
      dcnt <= 4'd10;
      dq   <= (bus.div_divisor == 0) ? 32'hFFFF_FFFF : bus.div_dividend / bus.div_divisor;
      dr   <= (bus.div_divisor == 0) ? bus.div_dividend : bus.div_dividend % bus.div_divisor;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 4'd1;
    end
  end
  assign bus.div_done      = (dcnt == 4'd1);
  assign bus.div_quotient  = dq;
  assign bus.div_remainder = dr;

  typedef struct {
    m_funct3_t   op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          done_cyc;
    int          mul_cyc;   // -1: no launch expected
    int          div_cyc;
  } vec_t;

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input m_funct3_t op, input logic [31:0] a, input logic [31:0] b);
    bus.m_valid  = 1'b1;
    bus.m_funct3 = op;
    bus.m_rs1    = a;
    bus.m_rs2    = b;
  endtask

  // Samples at negedges from the current cycle (relative cycle 0) until m_done.
  task automatic wait_done(input int budget, output int done_cyc, output logic [31:0] res,
                           output int mul_cyc, output int div_cyc, output logic stall0);
    done_cyc = -1; mul_cyc = -1; div_cyc = -1; res = '0; stall0 = 1'b0;
    for (int c = 0; c <= budget; c++) begin
      @(negedge clk);
      if (c == 0) stall0 = bus.m_stall;
      if (bus.mul_enable && mul_cyc < 0) mul_cyc = c;
      if (bus.div_start && div_cyc < 0) div_cyc = c;
      if (bus.m_done) begin
        done_cyc = c;
        res      = bus.m_result;
        break;
      end
    end
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    int          dc, mc, vc;
    logic [31:0] res;
    logic        st0;
    drive(v.op, v.a, v.b);
    wait_done(40, dc, res, mc, vc, st0);
    $display("%s: %s 0x%08h 0x%08h -> 0x%08h done@%0d mul@%0d div@%0d",
             tag, v.op.name(), v.a, v.b, res, dc, mc, vc);
    check({tag, " result"},     res,     v.res);
    check({tag, " done_cycle"}, dc,      v.done_cyc);
    check({tag, " mul_launch"}, mc,      v.mul_cyc);
    check({tag, " div_launch"}, vc,      v.div_cyc);
    check({tag, " stall"},      32'(st0), 32'd1);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    tick();
    apply_vec(tag, v);
  endtask

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB,  4,  1, -1};
    vecs[1]  = '{MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000,  4,  1, -1};
    vecs[2]  = '{MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000,  1, -1, -1};
    vecs[3]  = '{DIVU,   32'd100,       32'h0000_0000, 32'hFFFF_FFFF,  1, -1, -1};
    vecs[4]  = '{REM,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9,  1, -1, -1};
    vecs[5]  = '{DIV,    DIV_OVF_DIVIDEND, 32'hFFFF_FFFF, 32'h8000_0000, 1, -1, -1};
    vecs[6]  = '{REM,    DIV_OVF_DIVIDEND, 32'hFFFF_FFFF, 32'h0000_0000, 1, -1, -1};
    vecs[7]  = '{REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 12, -1,  1};
    vecs[8]  = '{DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 12, -1,  1};
    vecs[9]  = '{DIVU,   32'd100,       32'd7,         32'd14,        12, -1,  1};
    vecs[10] = '{REMU,   32'd100,       32'd7,         32'd2,         12, -1,  1};
    vecs[11] = '{MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF,  4,  1, -1};
    vecs[12] = '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE,  4,  1, -1};
    vecs[13] = '{MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001,  4,  1, -1};
    vecs[14] = '{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000,  1, -1, -1};
    vecs[15] = '{DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 12, -1,  1};
    vecs[16] = '{MUL,    32'd3,         32'd5,         32'd15,         4,  1, -1};

    bus.m_valid  = 1'b1;
    bus.m_funct3 = MUL;
    bus.m_rs1    = 32'd3;
    bus.m_rs2    = 32'd5;
    bus.flush    = 1'b0;

    // Outputs in reset, with an op pending.
    #12;
    check("rst m_stall",    32'(bus.m_stall),    32'd0);
    check("rst m_done",     32'(bus.m_done),     32'd0);
    check("rst mul_enable", 32'(bus.mul_enable), 32'd0);
    check("rst div_start",  32'(bus.div_start),  32'd0);
    check("rst m_result",   bus.m_result,        32'd0);
    bus.m_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Hit on the cached 3*5 product.
    run_vec("hit35", '{MUL, 32'd3, 32'd5, 32'd15, 1, -1, -1});

    // Flush in MUL_WAIT: no m_done, cache dropped, next MUL relaunches.
    tick();
    drive(MULH, 32'd9, 32'd9);
    tick();
    tick();
    bus.flush = 1'b1; bus.m_valid = 1'b0;
    @(negedge clk);
    check("mflush m_done", 32'(bus.m_done), 32'd0);
    check("mflush m_stall", 32'(bus.m_stall), 32'd0);
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    check("mdrain m_done", 32'(bus.m_done), 32'd0);
    $display("flush in MUL_WAIT applied");
    run_vec("after_mflush", '{MUL, 32'd3, 32'd5, 32'd15, 4, 1, -1});

    // Flush in DIV_WAIT: DRAIN holds off the next op until div_done.
    tick();
    drive(DIV, 32'd100, 32'd7);
    tick();
    tick();
    tick();
    bus.flush = 1'b1; bus.m_valid = 1'b0;
    @(negedge clk);
    check("dflush m_done", 32'(bus.m_done), 32'd0);
    tick();
    bus.flush = 1'b0;
    $display("flush in DIV_WAIT applied");
    apply_vec("drain_mulhu", '{MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 12, 9, -1});

    // Reset during MUL_WAIT: outputs drop at once, cache is cleared.
    tick();
    drive(MULH, 32'd6, 32'd7);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("arst m_stall",    32'(bus.m_stall),    32'd0);
    check("arst m_done",     32'(bus.m_done),     32'd0);
    check("arst mul_enable", 32'(bus.mul_enable), 32'd0);
    check("arst m_result",   bus.m_result,        32'd0);
    tick();
    bus.m_valid = 1'b0;
    tick();
    rst = 1'b1;
    $display("reset during MUL_WAIT applied");
    run_vec("after_rst", '{MUL, 32'd3, 32'd5, 32'd15, 4, 1, -1});

    tick();
    bus.m_valid = 1'b0;
    tick();
    tick();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
